// File: rtl/msg_rr_arb_3_to_1.sv
// rtl/msg_rr_arb_3_to_1.sv - registered 3:1 round-robin message arbiter with bounded burst
// Optional per-source grant counters are enabled by defining MSG_RR_ARB_STATS_EN.
module msg_rr_arb_3_to_1 #(
  parameter int BITWIDTH  = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [2:0]          in_valid,
  input  logic [BITWIDTH-1:0] in_data_0,
  input  logic [BITWIDTH-1:0] in_data_1,
  input  logic [BITWIDTH-1:0] in_data_2,
  output logic [2:0]          in_ready,
  output logic                out_valid,
  output logic [BITWIDTH-1:0] out_data,
  input  logic                out_ready,
  output logic [2:0]          out_src
`ifdef MSG_RR_ARB_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         grant_cnt_0,
  output logic [15:0]         grant_cnt_1,
  output logic [15:0]         grant_cnt_2
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

  logic [1:0]          rr_ptr;
  logic [1:0]          last_src;
  logic [CW-1:0]       burst_cnt;
  logic [2:0]          grant;
  logic [1:0]          grant_idx;
  logic [1:0]          ptr_inc;
  logic [CW-1:0]       burst_next;
  logic [BITWIDTH-1:0] mux_word;
  logic                load;
  logic                xfer;
  logic                others_valid;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    grant = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (in_valid[1])      grant = 3'b010;
        else if (in_valid[2]) grant = 3'b100;
        else if (in_valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if (in_valid[2])      grant = 3'b100;
        else if (in_valid[0]) grant = 3'b001;
        else if (in_valid[1]) grant = 3'b010;
      end
      default: begin
        if (in_valid[0])      grant = 3'b001;
        else if (in_valid[1]) grant = 3'b010;
        else if (in_valid[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    grant_idx = 2'd0;
    if (grant[1]) grant_idx = 2'd1;
    if (grant[2]) grant_idx = 2'd2;
  end

  assign ptr_inc      = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  assign burst_next   = (grant_idx == last_src) ? burst_cnt + 1'b1 : {{(CW-1){1'b0}}, 1'b1};
  assign others_valid = |(in_valid & ~grant);

  // Reset gates ready so no source sees a handshake that the reset discards.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {3{load & ~rst}};
  assign xfer     = |(in_valid & in_ready);

  assign mux_word = (in_data_0 & {BITWIDTH{grant[0]}})
                  ^ (in_data_1 & {BITWIDTH{grant[1]}})
                  ^ (in_data_2 & {BITWIDTH{grant[2]}});

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'b000;
      rr_ptr    <= 2'd0;
      burst_cnt <= '0;
      last_src  <= 2'd0;
    end else begin
      if (load) begin
        if (|grant) begin
          out_data  <= mux_word;
          out_src   <= grant;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (xfer) begin
        last_src <= grant_idx;
        // Burst exhausted or nobody else waiting: hand priority to the next source.
        if ((burst_next == MAX_B) || !others_valid) begin
          rr_ptr    <= ptr_inc;
          burst_cnt <= '0;
        end else begin
          rr_ptr    <= grant_idx;
          burst_cnt <= burst_next;
        end
      end
    end
  end

`ifdef MSG_RR_ARB_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (rst || stats_clr) begin
      grant_cnt_0 <= '0;
      grant_cnt_1 <= '0;
      grant_cnt_2 <= '0;
    end else if (xfer) begin
      if (grant[0] && grant_cnt_0 != 16'hFFFF) grant_cnt_0 <= grant_cnt_0 + 16'd1;
      if (grant[1] && grant_cnt_1 != 16'hFFFF) grant_cnt_1 <= grant_cnt_1 + 16'd1;
      if (grant[2] && grant_cnt_2 != 16'hFFFF) grant_cnt_2 <= grant_cnt_2 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_rr_arb_3_to_1.sv
// tb/tb_msg_rr_arb_3_to_1.sv - directed bench for msg_rr_arb_3_to_1
module tb_msg_rr_arb_3_to_1;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [4:0] in_data_0, in_data_1, in_data_2;
  logic [2:0] in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_ready;
  logic [2:0] out_src;
`ifdef MSG_RR_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt_0, grant_cnt_1, grant_cnt_2;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 sys_clk = ~sys_clk;

  msg_rr_arb_3_to_1 #(.BITWIDTH(5), .MAX_BURST(4)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef MSG_RR_ARB_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .grant_cnt_0 (grant_cnt_0),
    .grant_cnt_1 (grant_cnt_1),
    .grant_cnt_2 (grant_cnt_2)
`endif
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    in_data_0 = 5'd1; in_data_1 = 5'd2; in_data_2 = 5'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (in_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests_run++;
      if (out_src !== 3'b000) begin tests_failed++; $display("FAIL reset_out_src got=%b exp=000", out_src); end
      tests_run++;
      if (out_data !== 5'd0) begin tests_failed++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    end
  endtask

  // Releases reset with all sources valid; expects 4-word bursts rotating 0,1,2,0.
  task automatic test_burst();
    logic [2:0] exp_src;
    logic [4:0] exp_data;
    int idx;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      idx = (k / 4) % 3;
      exp_src  = 3'b001 << idx;
      exp_data = 5'(idx + 1);
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL burst_valid[%0d] got=%b exp=1", k, out_valid); end
      tests_run++;
      if (out_src !== exp_src) begin tests_failed++; $display("FAIL burst_src[%0d] got=%b exp=%b", k, out_src, exp_src); end
      tests_run++;
      if (out_data !== exp_data) begin tests_failed++; $display("FAIL burst_data[%0d] got=%0d exp=%0d", k, out_data, exp_data); end
    end
  endtask

  task automatic test_single_source();
    in_valid = 3'b010;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid[%0d] got=%b exp=1", k, out_valid); end
      tests_run++;
      if (out_src !== 3'b010) begin tests_failed++; $display("FAIL single_src[%0d] got=%b exp=010", k, out_src); end
      tests_run++;
      if (out_data !== 5'd2) begin tests_failed++; $display("FAIL single_data[%0d] got=%0d exp=2", k, out_data); end
    end
    // Pointer must now sit at source 2.
    in_valid = 3'b111;
    #1;
    tests_run++;
    if (in_ready !== 3'b100) begin tests_failed++; $display("FAIL single_ptr_ready got=%b exp=100", in_ready); end
  endtask

  task automatic test_stall();
    tick();
    tests_run++;
    if (out_src !== 3'b100 || out_data !== 5'd3) begin
      tests_failed++; $display("FAIL stall_first got src=%b data=%0d exp src=100 data=3", out_src, out_data);
    end
    out_ready = 1'b0;
    in_data_2 = 5'd7;
    #1;
    tests_run++;
    if (in_ready !== 3'b000) begin tests_failed++; $display("FAIL stall_in_ready got=%b exp=000", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== 3'b100 || out_data !== 5'd3) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got v=%b src=%b data=%0d exp v=1 src=100 data=3", c, out_valid, out_src, out_data);
      end
      tests_run++;
      if (in_ready !== 3'b000) begin tests_failed++; $display("FAIL stall_hold_ready[%0d] got=%b exp=000", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 3'b100) begin tests_failed++; $display("FAIL stall_release_ready got=%b exp=100", in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 3'b100 || out_data !== 5'd7) begin
      tests_failed++;
      $display("FAIL stall_release_load got v=%b src=%b data=%0d exp v=1 src=100 data=7", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_reset_handshake();
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 3'b000) begin tests_failed++; $display("FAIL rst_hs_in_ready got=%b exp=000", in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_src !== 3'b000 || out_data !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_hs_out got v=%b src=%b data=%0d exp v=0 src=000 data=0", out_valid, out_src, out_data);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 3'b001) begin tests_failed++; $display("FAIL rst_hs_ptr got=%b exp=001", in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 3'b001 || out_data !== 5'd1) begin
      tests_failed++;
      $display("FAIL rst_hs_next got v=%b src=%b data=%0d exp v=1 src=001 data=1", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_idle();
    in_valid = 3'b000;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_src !== 3'b001 || out_data !== 5'd1) begin
      tests_failed++;
      $display("FAIL idle_drain got v=%b src=%b data=%0d exp v=0 src=001 data=1", out_valid, out_src, out_data);
    end
    tick();
    in_valid = 3'b111;
    #1;
    tests_run++;
    if (in_ready !== 3'b001) begin tests_failed++; $display("FAIL idle_ptr_hold got=%b exp=001", in_ready); end
    in_valid = 3'b000;
  endtask

`ifdef MSG_RR_ARB_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    in_valid = 3'b001;
    for (int k = 0; k < 70000; k++) tick();
    tests_run++;
    if (grant_cnt_0 !== 16'hFFFF) begin tests_failed++; $display("FAIL stats_sat got=%h exp=ffff", grant_cnt_0); end
    tests_run++;
    if (grant_cnt_1 !== 16'h0000 || grant_cnt_2 !== 16'h0000) begin
      tests_failed++; $display("FAIL stats_others got=%h/%h exp=0000/0000", grant_cnt_1, grant_cnt_2);
    end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    in_valid = 3'b000;
    tests_run++;
    if (grant_cnt_0 !== 16'h0 || grant_cnt_1 !== 16'h0 || grant_cnt_2 !== 16'h0) begin
      tests_failed++; $display("FAIL stats_clr got=%h/%h/%h exp=0/0/0", grant_cnt_0, grant_cnt_1, grant_cnt_2);
    end
  endtask
`endif

  initial begin
`ifdef MSG_RR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_burst();
    test_single_source();
    test_stall();
    test_reset_handshake();
    test_idle();
`ifdef MSG_RR_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
